mod_counter: RTL

Parametrised up/down counter with programmable modulus, step size and terminal-behaviour mode (wrap, saturate, one-shot). It succeeds the fixed-range `counter` block. It adds runtime range control, a synchronous clear, a one-shot done flag and a registered terminal-count pulse. It is used as a general timebase and event counter in datapath and control blocks.

---
 rtl/mod_counter_pkg.sv | 12 +
 rtl/mod_counter_next.sv | 34 +++
 rtl/mod_counter.sv | 51 +++++
 3 files changed

// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: terminal-behaviour modes and step clamp shared by the modulo counter.
package mod_counter_pkg;
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_t;

  function automatic logic [63:0] eff_step(input logic [63:0] step, input logic [63:0] limit);
    return step > limit ? limit : step;
  endfunction
endpackage

// File: rtl/mod_counter_next.sv
// mod_counter_next: combinational next-count and terminal-event detection for one enabled step.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int STEP_W = 4
) (
  input  logic [SIZE-1:0]   count,
  input  logic [SIZE-1:0]   modulus,
  input  logic [STEP_W-1:0] step,
  input  logic              up_down,
  input  logic [1:0]        mode,
  output logic [SIZE-1:0]   next_count,
  output logic              terminal
);
  localparam int W = (SIZE > STEP_W ? SIZE : STEP_W) + 1;
  logic [W-1:0] c, m, m1, s, sum, n;
  logic over, wrap;
  // Widened so modulus+1 and count+step never lose a carry.
  always_comb begin
    c          = W'(count);
    m          = W'(modulus);
    m1         = m + W'(1);
    s          = W'(eff_step(64'(step), 64'(m1)));
    sum        = c + s;
    over       = c > m;
    wrap       = mode != MODE_SAT && mode != MODE_ONESHOT;
    terminal   = over || (up_down ? sum > m : c < s);
    n          = !terminal ? (up_down ? sum : c - s)
               : wrap ? (over ? '0 : up_down ? sum - m1 : c + m1 - s)
               : (over || up_down) ? m : '0;
    next_count = SIZE'(n);
  end
endmodule

// File: rtl/mod_counter.sv
// mod_counter: up/down counter with runtime modulus, step and wrap/saturate/one-shot behaviour.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              up_down,
  input  logic              clear,
  input  logic              load_en,
  input  logic [SIZE-1:0]   load,
  input  logic [SIZE-1:0]   modulus,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  output logic [SIZE-1:0]   count,
  output logic              pulse,
  output logic              done
);
  logic [SIZE-1:0] next_count;
  logic terminal, advance;

  mod_counter_next #(.SIZE(SIZE), .STEP_W(STEP_W)) u_next (
    .count(count), .modulus(modulus), .step(step), .up_down(up_down), .mode(mode),
    .next_count(next_count), .terminal(terminal)
  );

  assign advance = enable && step != '0 && !done;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count <= '0;
      pulse <= 1'b0;
      done  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      pulse <= 1'b0;
      done  <= 1'b0;
    end else if (load_en) begin
      count <= load > modulus ? modulus : load;
      pulse <= 1'b0;
      done  <= 1'b0;
    end else if (advance) begin
      count <= next_count;
      pulse <= terminal;
      done  <= terminal && mode == MODE_ONESHOT;
    end else
      pulse <= 1'b0;
endmodule
